// File: rtl/zynq_axil_fifo_csr_shell.sv
// AXI4-Lite slave shell exposing R/W CSRs, PS->PL FIFOs and PL->PS FIFOs with
// occupancy/free-space status words, all decoded from one flat word map.
module zynq_axil_fifo_csr_shell #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10,
  parameter int num_regs_p         = 4,
  parameter int num_in_fifos_p     = 2,
  parameter int num_out_fifos_p    = 2,
  parameter int fifo_els_p         = 4
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [3:0]                      s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [32*num_regs_p-1:0]        csr_data_o,
  output logic [32*num_in_fifos_p-1:0]    pl_in_data_o,
  output logic [num_in_fifos_p-1:0]       pl_in_v_o,
  input  logic [num_in_fifos_p-1:0]       pl_in_yumi_i,
  input  logic [32*num_out_fifos_p-1:0]   pl_out_data_i,
  input  logic [num_out_fifos_p-1:0]      pl_out_v_i,
  output logic [num_out_fifos_p-1:0]      pl_out_ready_o
);

  localparam int O        = num_out_fifos_p;
  localparam int I        = num_in_fifos_p;
  localparam int R        = num_regs_p;
  localparam int cw       = $clog2(fifo_els_p + 1);
  localparam int pw       = $clog2(fifo_els_p);
  localparam int BASE_IN  = 2 * O;
  localparam int BASE_IST = 2 * O + I;
  localparam int BASE_CSR = 2 * O + 2 * I;
  localparam int MAP_END  = BASE_CSR + R;

  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [1:0]    RESP_DECERR = 2'b11;
  localparam logic [cw-1:0] FULL_CNT    = cw'(fifo_els_p);
  localparam logic [pw-1:0] LAST_PTR    = pw'(fifo_els_p - 1);

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("zynq_axil_fifo_csr_shell supports only a 32-bit data width");
  end
  if (MAP_END > (1 << (C_S_AXI_ADDR_WIDTH - 2))) begin : g_bad_addr_width
    $error("zynq_axil_fifo_csr_shell word map does not fit the address width");
  end

  logic                bvalid_q, rvalid_q;
  logic [1:0]          bresp_q, rresp_q;
  logic [31:0]         rdata_q;
  logic [31:0]         csr_q   [R];
  logic [31:0]         in_mem  [I][fifo_els_p];
  logic [pw-1:0]       in_rd   [I];
  logic [pw-1:0]       in_wr   [I];
  logic [cw-1:0]       in_cnt  [I];
  logic [31:0]         out_mem [O][fifo_els_p];
  logic [pw-1:0]       out_rd  [O];
  logic [pw-1:0]       out_wr  [O];
  logic [cw-1:0]       out_cnt [O];

  logic                wr_acc, rd_acc;
  logic [31:0]         wword, rword;
  logic [1:0]          wr_resp, rd_resp;
  logic [31:0]         rd_data;
  logic [I-1:0]        in_push, in_pop;
  logic [O-1:0]        out_push, out_pop;
  logic [R-1:0]        csr_we;
  logic                unused_ok;

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign wword = 32'(s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2]);
  assign rword = 32'(s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]);

  // Ready is combinational so the accept happens in the cycle valid is seen.
  assign wr_acc        = aresetn && s_axi_awvalid && s_axi_wvalid && !bvalid_q;
  assign rd_acc        = aresetn && s_axi_arvalid && !rvalid_q;
  assign s_axi_awready = wr_acc;
  assign s_axi_wready  = wr_acc;
  assign s_axi_arready = rd_acc;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

  function automatic logic [pw-1:0] next_ptr(input logic [pw-1:0] p);
    return (p == LAST_PTR) ? '0 : p + pw'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < R; k++) csr_data_o[32*k +: 32] = csr_q[k];
    for (int i = 0; i < I; i++) begin
      pl_in_data_o[32*i +: 32] = in_mem[i][in_rd[i]];
      pl_in_v_o[i]             = (in_cnt[i] != '0);
    end
    for (int j = 0; j < O; j++) pl_out_ready_o[j] = (out_cnt[j] != FULL_CNT);
  end

  // A push into a full FIFO is still legal when the same edge pops it.
  always_comb begin
    wr_resp = RESP_SLVERR;
    in_push = '0;
    csr_we  = '0;
    for (int i = 0; i < I; i++) in_pop[i] = pl_in_yumi_i[i] && (in_cnt[i] != '0);
    for (int j = 0; j < O; j++) out_push[j] = pl_out_v_i[j] && (out_cnt[j] != FULL_CNT);
    if (wword >= 32'(MAP_END)) wr_resp = RESP_DECERR;
    for (int i = 0; i < I; i++) begin
      if (wword == 32'(BASE_IN + i) && (in_cnt[i] != FULL_CNT || in_pop[i])) begin
        wr_resp    = RESP_OKAY;
        in_push[i] = wr_acc;
      end
    end
    for (int k = 0; k < R; k++) begin
      if (wword == 32'(BASE_CSR + k)) begin
        wr_resp   = RESP_OKAY;
        csr_we[k] = wr_acc;
      end
    end
  end

  always_comb begin
    rd_resp = RESP_SLVERR;
    rd_data = '0;
    out_pop = '0;
    if (rword >= 32'(MAP_END)) rd_resp = RESP_DECERR;
    for (int j = 0; j < O; j++) begin
      if (rword == 32'(j) && out_cnt[j] != '0) begin
        rd_resp    = RESP_OKAY;
        rd_data    = out_mem[j][out_rd[j]];
        out_pop[j] = rd_acc;
      end
      if (rword == 32'(O + j)) begin
        rd_resp = RESP_OKAY;
        rd_data = 32'(out_cnt[j]);
      end
    end
    for (int i = 0; i < I; i++) begin
      if (rword == 32'(BASE_IST + i)) begin
        rd_resp = RESP_OKAY;
        rd_data = 32'(fifo_els_p) - 32'(in_cnt[i]);
      end
    end
    for (int k = 0; k < R; k++) begin
      if (rword == 32'(BASE_CSR + k)) begin
        rd_resp = RESP_OKAY;
        rd_data = csr_q[k];
      end
    end
  end

  always_ff @(posedge aclk) begin
    for (int i = 0; i < I; i++)
      if (in_push[i]) in_mem[i][in_wr[i]] <= s_axi_wdata;
    for (int j = 0; j < O; j++)
      if (out_push[j]) out_mem[j][out_wr[j]] <= pl_out_data_i[32*j +: 32];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      for (int k = 0; k < R; k++) csr_q[k] <= '0;
      for (int i = 0; i < I; i++) begin
        in_rd[i]  <= '0;
        in_wr[i]  <= '0;
        in_cnt[i] <= '0;
      end
      for (int j = 0; j < O; j++) begin
        out_rd[j]  <= '0;
        out_wr[j]  <= '0;
        out_cnt[j] <= '0;
      end
    end else begin
      if (wr_acc) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
      end else if (s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (rd_acc) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_resp;
        rdata_q  <= rd_data;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
      for (int k = 0; k < R; k++)
        for (int b = 0; b < 4; b++)
          if (csr_we[k] && s_axi_wstrb[b]) csr_q[k][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      for (int i = 0; i < I; i++) begin
        if (in_push[i]) in_wr[i] <= next_ptr(in_wr[i]);
        if (in_pop[i])  in_rd[i] <= next_ptr(in_rd[i]);
        if (in_push[i] && !in_pop[i])      in_cnt[i] <= in_cnt[i] + cw'(1);
        else if (!in_push[i] && in_pop[i]) in_cnt[i] <= in_cnt[i] - cw'(1);
      end
      for (int j = 0; j < O; j++) begin
        if (out_push[j]) out_wr[j] <= next_ptr(out_wr[j]);
        if (out_pop[j])  out_rd[j] <= next_ptr(out_rd[j]);
        if (out_push[j] && !out_pop[j])      out_cnt[j] <= out_cnt[j] + cw'(1);
        else if (!out_push[j] && out_pop[j]) out_cnt[j] <= out_cnt[j] - cw'(1);
      end
    end
  end

endmodule

// File: tb/tb_zynq_axil_fifo_csr_shell.sv
// Directed bench for zynq_axil_fifo_csr_shell with 2 out FIFOs, 2 in FIFOs,
// 4 CSRs and depth-4 FIFOs (word map: out data 0-1, occ 2-3, in data 4-5, free 6-7, CSR 8-11).
module tb_zynq_axil_fifo_csr_shell;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [9:0]   s_axi_awaddr;
  logic [2:0]   s_axi_awprot;
  logic         s_axi_awvalid, s_axi_awready;
  logic [31:0]  s_axi_wdata;
  logic [3:0]   s_axi_wstrb;
  logic         s_axi_wvalid, s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid, s_axi_bready;
  logic [9:0]   s_axi_araddr;
  logic [2:0]   s_axi_arprot;
  logic         s_axi_arvalid, s_axi_arready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rvalid, s_axi_rready;
  logic [127:0] csr_data_o;
  logic [63:0]  pl_in_data_o;
  logic [1:0]   pl_in_v_o, pl_in_yumi_i;
  logic [63:0]  pl_out_data_i;
  logic [1:0]   pl_out_v_i, pl_out_ready_o;

  int checks = 0;
  int errors = 0;

  zynq_axil_fifo_csr_shell dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .csr_data_o(csr_data_o),
    .pl_in_data_o(pl_in_data_o), .pl_in_v_o(pl_in_v_o), .pl_in_yumi_i(pl_in_yumi_i),
    .pl_out_data_i(pl_out_data_i), .pl_out_v_i(pl_out_v_i), .pl_out_ready_o(pl_out_ready_o)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no completion expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    errors++;
    $display("[TB] FAIL %s: observed timeout expected handshake", tag);
  endtask

  task automatic applyStimulus(input logic [1:0] yumi, input logic [1:0] out_v, input logic [63:0] out_data);
    pl_in_yumi_i  = yumi;
    pl_out_v_i    = out_v;
    pl_out_data_i = out_data;
  endtask

  task automatic axi_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    int n;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_axi_awready && n < 50) begin n++; @(negedge aclk); end
    if (!s_axi_awready) timeoutFail("aw_accept");
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_axi_bvalid && n < 50) begin n++; @(negedge aclk); end
    if (!s_axi_bvalid) timeoutFail("b_valid");
    resp = s_axi_bresp;
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [9:0] addr, input bit clear_push,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_axi_arready && n < 50) begin n++; @(negedge aclk); end
    if (!s_axi_arready) timeoutFail("ar_accept");
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    if (clear_push) pl_out_v_i = 2'b00;
    n = 0;
    @(negedge aclk);
    while (!s_axi_rvalid && n < 50) begin n++; @(negedge aclk); end
    if (!s_axi_rvalid) timeoutFail("r_valid");
    data = s_axi_rdata;
    resp = s_axi_rresp;
    @(posedge aclk); #1;
    s_axi_rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;

    aresetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_araddr = '0; s_axi_arprot = '0;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    applyStimulus(2'b00, 2'b00, 64'h0);
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rst_awready", s_axi_awready, 1'b0);
    checkOutput("rst_arready", s_axi_arready, 1'b0);
    checkOutput("rst_bvalid", s_axi_bvalid, 1'b0);
    checkOutput("rst_rvalid", s_axi_rvalid, 1'b0);
    checkOutput("rst_rdata", s_axi_rdata, 32'h0);
    checkOutput("rst_in_v", pl_in_v_o, 2'b00);
    checkOutput("rst_csr", csr_data_o, 128'h0);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    checkOutput("out_ready_after_rst", pl_out_ready_o, 2'b11);

    $display("[TB] CSR byte-strobe write");
    axi_write(10'h020, 32'hA5A5_1234, 4'b0011, resp);
    checkOutput("csr0_bresp", resp, 2'b00);
    checkOutput("csr0_out", csr_data_o[31:0], 32'h0000_1234);
    axi_read(10'h020, 1'b0, rd, resp);
    checkOutput("csr0_rdata", rd, 32'h0000_1234);
    checkOutput("csr0_rresp", resp, 2'b00);

    $display("[TB] PS->PL FIFO fill, overflow and drain");
    for (int k = 1; k <= 4; k++) begin
      axi_write(10'h010, 32'(k), 4'b1111, resp);
      checkOutput("in0_push_bresp", resp, 2'b00);
    end
    checkOutput("in0_v_full", pl_in_v_o, 2'b01);
    axi_write(10'h010, 32'd5, 4'b1111, resp);
    checkOutput("in0_overflow_bresp", resp, 2'b10);
    axi_read(10'h018, 1'b0, rd, resp);
    checkOutput("in0_free_full", rd, 32'd0);
    axi_read(10'h010, 1'b0, rd, resp);
    checkOutput("in0_data_read_resp", resp, 2'b10);
    checkOutput("in0_data_read_rdata", rd, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge aclk);
      checkOutput("in0_head", pl_in_data_o[31:0], 32'(k));
      checkOutput("in0_v", pl_in_v_o[0], 1'b1);
      pl_in_yumi_i = 2'b01;
    end
    @(posedge aclk); #1;
    pl_in_yumi_i = 2'b00;
    checkOutput("in0_v_empty", pl_in_v_o, 2'b00);
    axi_read(10'h018, 1'b0, rd, resp);
    checkOutput("in0_free_empty", rd, 32'd4);

    $display("[TB] PL->PS FIFO push and pop");
    applyStimulus(2'b00, 2'b10, {32'h11, 32'h0});
    @(posedge aclk); #1;
    applyStimulus(2'b00, 2'b10, {32'h22, 32'h0});
    @(posedge aclk); #1;
    applyStimulus(2'b00, 2'b00, 64'h0);
    axi_read(10'h00C, 1'b0, rd, resp);
    checkOutput("out1_occ", rd, 32'd2);
    axi_read(10'h004, 1'b0, rd, resp);
    checkOutput("out1_pop1", rd, 32'h11);
    checkOutput("out1_pop1_resp", resp, 2'b00);
    axi_read(10'h004, 1'b0, rd, resp);
    checkOutput("out1_pop2", rd, 32'h22);
    axi_read(10'h004, 1'b0, rd, resp);
    checkOutput("out1_empty_rdata", rd, 32'h0);
    checkOutput("out1_empty_resp", resp, 2'b10);

    $display("[TB] Simultaneous push/pop across pointer wrap");
    applyStimulus(2'b00, 2'b01, {32'h0, 32'hA0});
    @(posedge aclk); #1;
    applyStimulus(2'b00, 2'b00, 64'h0);
    for (int n = 0; n < 10; n++) begin
      applyStimulus(2'b00, 2'b01, {32'h0, 32'(8'hA1 + n)});
      axi_read(10'h000, 1'b1, rd, resp);
      checkOutput("out0_wrap_pop", rd, 32'(8'hA0 + n));
    end
    axi_read(10'h008, 1'b0, rd, resp);
    checkOutput("out0_wrap_occ", rd, 32'd1);
    axi_read(10'h000, 1'b0, rd, resp);
    checkOutput("out0_wrap_last", rd, 32'hAA);

    $display("[TB] Same-cycle read/write with stalled bready");
    s_axi_awaddr = 10'h024; s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'b1111;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_araddr = 10'h024; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b0; s_axi_rready = 1'b1;
    @(negedge aclk);
    checkOutput("dual_awready", s_axi_awready, 1'b1);
    checkOutput("dual_arready", s_axi_arready, 1'b1);
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
    s_axi_awaddr = 10'h028; s_axi_wdata = 32'h0000_0055;
    @(negedge aclk);
    checkOutput("dual_rvalid", s_axi_rvalid, 1'b1);
    checkOutput("dual_old_value", s_axi_rdata, 32'h0);
    @(posedge aclk); #1;
    s_axi_rready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      checkOutput("stall_bvalid", s_axi_bvalid, 1'b1);
      checkOutput("stall_no_accept", s_axi_awready, 1'b0);
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checkOutput("stall_bresp", s_axi_bresp, 2'b00);
    s_axi_bready = 1'b1;
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
    checkOutput("stall_bvalid_clear", s_axi_bvalid, 1'b0);
    checkOutput("stall_csr", csr_data_o, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0000_1234});

    $display("[TB] Decode errors");
    axi_write(10'h030, 32'hFFFF_FFFF, 4'b1111, resp);
    checkOutput("decerr_bresp", resp, 2'b11);
    axi_read(10'h030, 1'b0, rd, resp);
    checkOutput("decerr_rresp", resp, 2'b11);
    checkOutput("decerr_rdata", rd, 32'h0);
    axi_read(10'h3FC, 1'b0, rd, resp);
    checkOutput("decerr_top_rresp", resp, 2'b11);
    axi_write(10'h008, 32'h1, 4'b1111, resp);
    checkOutput("status_write_bresp", resp, 2'b10);
    axi_write(10'h000, 32'h1, 4'b1111, resp);
    checkOutput("outdata_write_bresp", resp, 2'b10);
    checkOutput("decerr_csr", csr_data_o, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0000_1234});
    checkOutput("decerr_in_v", pl_in_v_o, 2'b00);

    $display("[TB] Reset with pending response");
    axi_write(10'h014, 32'h77, 4'b1111, resp);
    checkOutput("in1_push_bresp", resp, 2'b00);
    applyStimulus(2'b00, 2'b01, {32'h0, 32'hBB});
    @(posedge aclk); #1;
    applyStimulus(2'b00, 2'b00, 64'h0);
    checkOutput("pre_rst_in_v", pl_in_v_o, 2'b10);
    s_axi_awaddr = 10'h02C; s_axi_wdata = 32'h99; s_axi_wstrb = 4'b1111;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge aclk);
    checkOutput("pre_rst_bvalid", s_axi_bvalid, 1'b1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    checkOutput("mid_rst_bvalid", s_axi_bvalid, 1'b0);
    checkOutput("mid_rst_in_v", pl_in_v_o, 2'b00);
    checkOutput("mid_rst_csr", csr_data_o, 128'h0);
    aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("post_rst_bvalid", s_axi_bvalid, 1'b0);
    checkOutput("post_rst_out_ready", pl_out_ready_o, 2'b11);
    axi_read(10'h008, 1'b0, rd, resp);
    checkOutput("post_rst_out0_occ", rd, 32'd0);
    axi_read(10'h000, 1'b0, rd, resp);
    checkOutput("post_rst_out0_pop_resp", resp, 2'b10);
    axi_read(10'h01C, 1'b0, rd, resp);
    checkOutput("post_rst_in1_free", rd, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
